// File: rtl/lsq_scheduler.sv
// Load/store queue scheduler: a circular queue of memory ops that issues one
// op at a time to the LSU, holds stores until the ROB commits them, and handles flush.
module lsq_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic                     enq_is_load,
    input  logic                     enq_is_store,
    input  logic                     enq_is_byte,
    input  logic                     enq_is_word,
    input  logic [31:0]              enq_rs1,
    input  logic [31:0]              enq_rs2,
    input  logic [31:0]              enq_imm,
    input  logic [TAG_W-1:0]         enq_tag,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     flush,
    output logic [31:0]              lsu_rs1_data,
    output logic [31:0]              lsu_rs2_data,
    output logic [31:0]              lsu_imm,
    output logic                     lsu_is_load,
    output logic                     lsu_is_store,
    output logic                     lsu_is_byte,
    output logic                     lsu_is_word,
    input  logic                     lsu_mem_done,
    input  logic [31:0]              lsu_read_data,
    output logic                     cpl_valid,
    output logic [TAG_W-1:0]         cpl_tag,
    output logic [31:0]              cpl_data,
    output logic                     cpl_is_load,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    // Entry payload (no reset needed; validity comes from head/count)
    logic [31:0]      rs1_mem [DEPTH];
    logic [31:0]      rs2_mem [DEPTH];
    logic [31:0]      imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [DEPTH-1:0] is_load_mem;
    logic [DEPTH-1:0] is_store_mem;
    logic [DEPTH-1:0] is_byte_mem;
    logic [DEPTH-1:0] is_word_mem;

    logic [DEPTH-1:0] committed_reg, committed_next;
    logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] commit_cnt_reg, commit_cnt_next;
    logic [CNT_W-1:0] new_commits, commit_eff;
    logic [1:0]       state_reg, state_next;
    logic             flush_pending_reg, flush_pending_next;
    logic             inflight_store_reg;

    logic [31:0]      lsu_rs1_reg, lsu_rs2_reg, lsu_imm_reg;
    logic             lsu_is_load_reg, lsu_is_store_reg, lsu_is_byte_reg, lsu_is_word_reg;
    logic             cpl_valid_reg, cpl_is_load_reg;
    logic [TAG_W-1:0] cpl_tag_reg;
    logic [31:0]      cpl_data_reg;

    logic [DEPTH-1:0] entry_valid, store_op, commit_hit;
    logic             do_enq, head_is_load, head_is_store, head_committed_eff;
    logic             issue_ok, flush_eff, kill_inflight, pop, pop_store;

    assign enq_ready = (count_reg < DEPTH_CNT);
    assign do_enq    = enq_valid && enq_ready && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - head_reg;
            assign entry_valid[gi] = {1'b0, offset} < count_reg;
            assign store_op[gi]    = is_store_mem[gi] && !is_load_mem[gi];
            assign commit_hit[gi]  = commit_valid && entry_valid[gi] && store_op[gi]
                                     && !committed_reg[gi] && (tag_mem[gi] == commit_tag);
        end
    endgenerate

    always_comb begin
        new_commits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            new_commits = new_commits + CNT_W'(commit_hit[i]);
        end
    end

    assign commit_eff         = commit_cnt_reg + new_commits;
    assign head_is_load       = is_load_mem[head_reg];
    assign head_is_store      = store_op[head_reg];
    assign head_committed_eff = committed_reg[head_reg] || commit_hit[head_reg];

    // A load at head is not issued in a flush cycle since the flush squashes it
    assign issue_ok = (state_reg == IDLE) && (count_reg != '0)
                      && ((head_is_store && head_committed_eff) || (head_is_load && !flush));

    // A flush seen in ISSUE is acted on by the FSM during the first WAIT cycle
    assign flush_eff     = flush || flush_pending_reg;
    assign kill_inflight = (state_reg == WAIT) && flush_eff && !inflight_store_reg;
    assign pop           = (state_reg == WAIT) && lsu_mem_done && !kill_inflight;
    assign pop_store     = pop && head_is_store;

    always_comb begin
        head_next       = head_reg + PTR_W'(pop);
        commit_cnt_next = commit_eff - CNT_W'(pop_store);
        if (flush) begin
            count_next = commit_eff - CNT_W'(pop);
            tail_next  = head_reg + commit_eff[PTR_W-1:0];
        end else begin
            count_next = count_reg + CNT_W'(do_enq) - CNT_W'(pop);
            tail_next  = tail_reg + PTR_W'(do_enq);
        end
        committed_next = committed_reg | commit_hit;
        if (do_enq) begin
            committed_next[tail_reg] = 1'b0;
        end
    end

    always_comb begin
        state_next         = state_reg;
        flush_pending_next = 1'b0;
        case (state_reg)
            IDLE:  if (issue_ok) state_next = ISSUE;
            ISSUE: begin
                state_next         = WAIT;
                flush_pending_next = flush;
            end
            WAIT: begin
                if (kill_inflight) begin
                    state_next = lsu_mem_done ? IDLE : DRAIN;
                end else if (lsu_mem_done) begin
                    state_next = IDLE;
                end
            end
            DRAIN: if (lsu_mem_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            rs1_mem[tail_reg]      <= enq_rs1;
            rs2_mem[tail_reg]      <= enq_rs2;
            imm_mem[tail_reg]      <= enq_imm;
            tag_mem[tail_reg]      <= enq_tag;
            is_load_mem[tail_reg]  <= enq_is_load;
            is_store_mem[tail_reg] <= enq_is_store;
            is_byte_mem[tail_reg]  <= enq_is_byte;
            is_word_mem[tail_reg]  <= enq_is_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg           <= '0;
            tail_reg           <= '0;
            count_reg          <= '0;
            commit_cnt_reg     <= '0;
            committed_reg      <= '0;
            state_reg          <= IDLE;
            flush_pending_reg  <= 1'b0;
            inflight_store_reg <= 1'b0;
            lsu_rs1_reg        <= '0;
            lsu_rs2_reg        <= '0;
            lsu_imm_reg        <= '0;
            lsu_is_load_reg    <= 1'b0;
            lsu_is_store_reg   <= 1'b0;
            lsu_is_byte_reg    <= 1'b0;
            lsu_is_word_reg    <= 1'b0;
            cpl_valid_reg      <= 1'b0;
            cpl_tag_reg        <= '0;
            cpl_data_reg       <= '0;
            cpl_is_load_reg    <= 1'b0;
        end else begin
            head_reg          <= head_next;
            tail_reg          <= tail_next;
            count_reg         <= count_next;
            commit_cnt_reg    <= commit_cnt_next;
            committed_reg     <= committed_next;
            state_reg         <= state_next;
            flush_pending_reg <= flush_pending_next;
            lsu_is_load_reg   <= issue_ok && head_is_load;
            lsu_is_store_reg  <= issue_ok && head_is_store;
            if (issue_ok) begin
                inflight_store_reg <= head_is_store;
                lsu_rs1_reg        <= rs1_mem[head_reg];
                lsu_rs2_reg        <= rs2_mem[head_reg];
                lsu_imm_reg        <= imm_mem[head_reg];
                lsu_is_byte_reg    <= is_byte_mem[head_reg];
                lsu_is_word_reg    <= is_word_mem[head_reg];
            end
            cpl_valid_reg <= pop;
            if (pop) begin
                cpl_tag_reg     <= tag_mem[head_reg];
                cpl_data_reg    <= head_is_load ? lsu_read_data : 32'd0;
                cpl_is_load_reg <= head_is_load;
            end
        end
    end

    assign lsu_rs1_data = lsu_rs1_reg;
    assign lsu_rs2_data = lsu_rs2_reg;
    assign lsu_imm      = lsu_imm_reg;
    assign lsu_is_load  = lsu_is_load_reg;
    assign lsu_is_store = lsu_is_store_reg;
    assign lsu_is_byte  = lsu_is_byte_reg;
    assign lsu_is_word  = lsu_is_word_reg;
    assign cpl_valid    = cpl_valid_reg;
    assign cpl_tag      = cpl_tag_reg;
    assign cpl_data     = cpl_data_reg;
    assign cpl_is_load  = cpl_is_load_reg;
    assign count        = count_reg;

endmodule
